// File: rtl/sop_func_unit_if.sv
// sop_func_unit_if: code stream, result stream and mask config bus for sop_func_unit
// cfg_pos is present only when POS_MODE_EN is defined.
interface sop_func_unit_if #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 3
);
    localparam int M  = 2 ** N_IN;
    localparam int SW = N_OUT > 1 ? $clog2(N_OUT) : 1;
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  a;
    logic             out_valid;
    logic             out_ready;
    logic [N_OUT-1:0] f;
    logic             cfg_we;
    logic [SW-1:0]    cfg_sel;
    logic [M-1:0]     cfg_data;
`ifdef POS_MODE_EN
    logic             cfg_pos;
    modport master (output in_valid, a, out_ready, cfg_we, cfg_sel, cfg_data, cfg_pos,
                    input in_ready, out_valid, f);
    modport slave  (input in_valid, a, out_ready, cfg_we, cfg_sel, cfg_data, cfg_pos,
                    output in_ready, out_valid, f);
`else
    modport master (output in_valid, a, out_ready, cfg_we, cfg_sel, cfg_data,
                    input in_ready, out_valid, f);
    modport slave  (input in_valid, a, out_ready, cfg_we, cfg_sel, cfg_data,
                    output in_ready, out_valid, f);
`endif
endinterface

// File: rtl/sop_func_unit.sv
// sop_func_unit: programmable multi-output sum-of-minterms generator, two-stage valid/ready pipeline
// Define POS_MODE_EN to add a per-output product-of-maxterms mode selected by cfg_pos.
module sop_func_unit #(
    parameter int                         N_IN  = 3,
    parameter int                         N_OUT = 3,
    parameter logic [N_OUT*(2**N_IN)-1:0] INIT  = 24'h9D_09_94
) (
    input logic            clk,
    input logic            rst_n,
    sop_func_unit_if.slave bus
);
    localparam int M = 2 ** N_IN;
    logic [M-1:0]     mask [N_OUT];
    logic [N_OUT-1:0] pos;
    logic [M-1:0]     dec;
    logic [N_OUT-1:0] fn;
    logic             s1_valid;
    logic             adv;
    logic             accept;
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || adv;
    assign accept       = bus.in_valid && bus.in_ready;
    // pos inverts the OR of selected minterms into a product of maxterms
    always_comb begin
        fn = '0;
        for (int j = 0; j < N_OUT; j++) fn[j] = (|(dec & mask[j])) ^ pos[j];
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            dec           <= '0;
            bus.out_valid <= 1'b0;
            bus.f         <= '0;
        end else begin
            if (accept) dec <= M'(1) << bus.a;
            s1_valid <= accept || (s1_valid && !adv);
            if (adv) bus.out_valid <= s1_valid;
            if (adv && s1_valid) bus.f <= fn;
        end
    // out-of-range cfg_sel matches no output, so such writes fall away
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int j = 0; j < N_OUT; j++) mask[j] <= INIT[j*M +: M];
`ifdef POS_MODE_EN
            pos <= '0;
`endif
        end else if (bus.cfg_we) begin
            for (int j = 0; j < N_OUT; j++)
                if (int'(bus.cfg_sel) == j) begin
                    mask[j] <= bus.cfg_data;
`ifdef POS_MODE_EN
                    pos[j] <= bus.cfg_pos;
`endif
                end
        end
`ifndef POS_MODE_EN
    assign pos = '0;
`endif
endmodule
